// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 8 data bits LSB first, even parity, one stop bit.
// Recovers each byte from the synchronised line and flags parity and stop-bit errors.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_valid,
  output logic       RxD_parity_err,
  output logic       RxD_frame_err,
  output logic       RxD_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  // A set result means the received parity bit disagrees with the data.
  function automatic logic parity_mismatch(input logic [7:0] data, input logic pbit);
    return pbit ^ (^data);
  endfunction

  logic             sync1_q, sync2_q;
  logic             rxd_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             perr_q, perr_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;

  assign rxd_s = sync2_q;

  // Next-state and next-output computation for the receive FSM.
  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    busy_d       = busy_q;
    case (state_q)
      S_IDLE: begin
        if (!rxd_s) begin
          state_d   = S_START;
          clk_cnt_d = CNT_ZERO;
          busy_d    = 1'b1;
        end else begin
          busy_d    = 1'b0;
        end
      end
      S_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = CNT_ZERO;
          if (rxd_s) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = CNT_ZERO;
          shift_d   = {rxd_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      S_PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = CNT_ZERO;
          perr_d    = parity_mismatch(shift_q, rxd_s);
          state_d   = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        // Deliver on the stop sample even when flagged; returning to IDLE here
        // leaves half a bit of margin for a back-to-back start bit.
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d    = CNT_ZERO;
          data_d       = shift_q;
          parity_err_d = perr_q;
          frame_err_d  = ~rxd_s;
          valid_d      = 1'b1;
          if (rxd_s) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      S_WAIT_IDLE: begin
        if (rxd_s) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Line synchroniser (idles high) and all FSM/output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= S_IDLE;
      clk_cnt_q    <= CNT_ZERO;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      perr_q       <= 1'b0;
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= RxD;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign RxD_data       = data_q;
  assign RxD_valid      = valid_q;
  assign RxD_parity_err = parity_err_q;
  assign RxD_frame_err  = frame_err_q;
  assign RxD_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: drives serial frames and checks every
// received byte, its flags and the exact cycle of its valid pulse.
module tb_uart_rx_deframer;

  localparam int CPB = 16;

  logic       Clk;
  logic       Rst_n;
  logic       RxD;
  logic [7:0] RxD_data;
  logic       RxD_valid;
  logic       RxD_parity_err;
  logic       RxD_frame_err;
  logic       RxD_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } pulse_t;

  pulse_t pq[$];

  uart_rx_deframer #(.CLKS_PER_BIT(CPB)) dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .RxD            (RxD),
    .RxD_data       (RxD_data),
    .RxD_valid      (RxD_valid),
    .RxD_parity_err (RxD_parity_err),
    .RxD_frame_err  (RxD_frame_err),
    .RxD_busy       (RxD_busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Edge index: the value seen just after edge n is n.
  always @(posedge Clk) cyc <= cyc + 1;

  // Every valid pulse is logged with the edge that raised it.
  always @(negedge Clk) begin
    if (RxD_valid === 1'b1) begin
      pq.push_back('{cyc, RxD_data, RxD_parity_err, RxD_frame_err});
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // t0 returns the index of the first edge that sees the start bit.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, output int t0);
    t0  = cyc + 1;
    RxD = 1'b0;
    repeat (CPB) tick();
    for (int k = 0; k < 8; k++) begin
      RxD = d[k];
      repeat (CPB) tick();
    end
    RxD = pbit;
    repeat (CPB) tick();
    RxD = sbit;
    repeat (CPB) tick();
  endtask

  task automatic check_pulse(input string tag, input int exp_cyc, input logic [7:0] d,
                             input logic pe, input logic fe);
    pulse_t p;
    check({tag, "_count"}, 32'(pq.size()) == 32'd0 ? 32'd0 : 32'd1, 32'd1);
    if (pq.size() > 0) begin
      p = pq.pop_front();
      check({tag, "_cycle"}, 32'(p.cyc), 32'(exp_cyc));
      check({tag, "_data"},  {24'd0, p.d}, {24'd0, d});
      check({tag, "_perr"},  {31'd0, p.pe}, {31'd0, pe});
      check({tag, "_ferr"},  {31'd0, p.fe}, {31'd0, fe});
    end
  endtask

  initial begin
    int t0;
    int ta;
    RxD   = 1'b1;
    Rst_n = 1'b0;
    repeat (3) tick();
    check("rst_data",  {24'd0, RxD_data}, 32'd0);
    check("rst_valid", {31'd0, RxD_valid}, 32'd0);
    check("rst_perr",  {31'd0, RxD_parity_err}, 32'd0);
    check("rst_ferr",  {31'd0, RxD_frame_err}, 32'd0);
    check("rst_busy",  {31'd0, RxD_busy}, 32'd0);

    Rst_n = 1'b1;
    repeat (100) tick();
    check("idle_pulses", 32'(pq.size()), 32'd0);
    check("idle_busy",   {31'd0, RxD_busy}, 32'd0);
    check("idle_data",   {24'd0, RxD_data}, 32'd0);

    send_frame(8'hA5, 1'b0, 1'b1, t0);
    repeat (4) tick();
    check_pulse("a5", t0 + 170, 8'hA5, 1'b0, 1'b0);
    check("a5_busy_after", {31'd0, RxD_busy}, 32'd0);
    check("a5_hold",       {24'd0, RxD_data}, 32'h0000_00A5);

    send_frame(8'h3C, 1'b1, 1'b1, t0);
    repeat (4) tick();
    check_pulse("3c_badpar", t0 + 170, 8'h3C, 1'b1, 1'b0);

    send_frame(8'h81, 1'b0, 1'b0, t0);
    repeat (40) tick();
    check("81_busy_break", {31'd0, RxD_busy}, 32'd1);
    check_pulse("81_break", t0 + 170, 8'h81, 1'b0, 1'b1);
    check("81_ferr_hold", {31'd0, RxD_frame_err}, 32'd1);
    RxD = 1'b1;
    repeat (5) tick();
    check("81_busy_released", {31'd0, RxD_busy}, 32'd0);
    check("81_no_retrigger", 32'(pq.size()), 32'd0);
    send_frame(8'h7E, 1'b0, 1'b1, t0);
    repeat (4) tick();
    check_pulse("7e", t0 + 170, 8'h7E, 1'b0, 1'b0);

    RxD = 1'b0;
    repeat (3) tick();
    check("glitch_busy", {31'd0, RxD_busy}, 32'd1);
    RxD = 1'b1;
    repeat (20) tick();
    check("glitch_idle",   {31'd0, RxD_busy}, 32'd0);
    check("glitch_nopulse", 32'(pq.size()), 32'd0);
    send_frame(8'h55, 1'b0, 1'b1, t0);
    repeat (4) tick();
    check_pulse("55", t0 + 170, 8'h55, 1'b0, 1'b0);

    send_frame(8'h00, 1'b0, 1'b1, ta);
    send_frame(8'hFF, 1'b0, 1'b1, t0);
    send_frame(8'h5A, 1'b0, 1'b1, t0);
    repeat (4) tick();
    check("b2b_count", 32'(pq.size()), 32'd3);
    check_pulse("b2b_00", ta + 170, 8'h00, 1'b0, 1'b0);
    check_pulse("b2b_ff", ta + 170 + 11 * CPB, 8'hFF, 1'b0, 1'b0);
    check_pulse("b2b_5a", ta + 170 + 22 * CPB, 8'h5A, 1'b0, 1'b0);

    // Fourth frame 0xC3 aborted by reset halfway through data bit 3.
    RxD = 1'b0;
    repeat (CPB) tick();
    RxD = 1'b1;
    repeat (CPB) tick();
    RxD = 1'b1;
    repeat (CPB) tick();
    RxD = 1'b0;
    repeat (CPB) tick();
    RxD = 1'b0;
    repeat (CPB / 2) tick();
    check("abort_busy_before", {31'd0, RxD_busy}, 32'd1);
    Rst_n = 1'b0;
    #1;
    check("abort_data",  {24'd0, RxD_data}, 32'd0);
    check("abort_valid", {31'd0, RxD_valid}, 32'd0);
    check("abort_perr",  {31'd0, RxD_parity_err}, 32'd0);
    check("abort_ferr",  {31'd0, RxD_frame_err}, 32'd0);
    check("abort_busy",  {31'd0, RxD_busy}, 32'd0);
    repeat (2) tick();
    RxD   = 1'b1;
    Rst_n = 1'b1;
    repeat (200) tick();
    check("abort_nopulse", 32'(pq.size()), 32'd0);
    check("abort_idle",    {31'd0, RxD_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
